hash_round_ctrl: RTL



---
 rtl/hash_pkg.sv | 29 ++
 rtl/hash_round_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/hash_pkg.sv
// Shared definitions for the hash round controller and its round datapath:
// state codes, the 4-byte chaining-state type and byte/word packing helpers.
package hash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CALC_SA    = 3'd1,
    ST_CALC_ROUND = 3'd2,
    ST_DONE       = 3'd3
  } hash_state_e;

  // Four bytes, index 0..3; byte i of a 32-bit word lives in bits [8*i+7:8*i].
  typedef logic [0:3][7:0] hword_t;

  localparam logic [31:0] IV_DEFAULT = 32'h6A09_E667;

  function automatic hword_t word_to_hw(input logic [31:0] w);
    hword_t h;
    for (int i = 0; i < 4; i++) h[i] = w[8*i +: 8];
    return h;
  endfunction

  function automatic logic [31:0] hw_to_word(input hword_t h);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = h[i];
    return w;
  endfunction

endpackage

// File: rtl/hash_round_ctrl.sv
// Sequencer for the external hash round datapath: owns the chaining state H.
// Optional macro HASH_ROUND_CTRL_PERF_CNT_EN adds the perf_rounds counter.
module hash_round_ctrl
  import hash_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 4,
  parameter logic [31:0] IV_INIT    = IV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [31:0] msg_word,
  input  logic        msg_last,
  output logic [2:0]  round_state,
  output hword_t      round_h_in,
  output hword_t      round_iv,
  input  hword_t      round_h_out,
  output logic        digest_valid,
  input  logic        digest_ready,
  output logic [31:0] digest,
  output logic        busy
`ifdef HASH_ROUND_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] perf_rounds
`endif
);

  localparam logic [2:0] S_IDLE       = ST_IDLE;
  localparam logic [2:0] S_CALC_SA    = ST_CALC_SA;
  localparam logic [2:0] S_CALC_ROUND = ST_CALC_ROUND;
  localparam logic [2:0] S_DONE       = ST_DONE;
  localparam logic [3:0] LAST_RND     = 4'(NUM_ROUNDS - 1);

  logic [2:0] r_state;
  hword_t     r_h;
  hword_t     r_w;
  logic [3:0] r_rnd_cnt;
  logic       r_last;
  hword_t     w_iv_round;

  assign w_iv_round = word_to_hw(IV_INIT) ^ {4{{4'b0000, r_rnd_cnt}}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_h       <= word_to_hw(IV_INIT);
      r_w       <= '0;
      r_rnd_cnt <= '0;
      r_last    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (msg_valid) begin
            r_w     <= word_to_hw(msg_word);
            r_last  <= msg_last;
            r_state <= S_CALC_SA;
          end
        end
        S_CALC_SA: begin
          r_h       <= round_h_out;
          r_rnd_cnt <= '0;
          r_state   <= S_CALC_ROUND;
        end
        S_CALC_ROUND: begin
          r_h       <= round_h_out;
          r_rnd_cnt <= r_rnd_cnt + 4'd1;
          if (r_rnd_cnt == LAST_RND) r_state <= r_last ? S_DONE : S_IDLE;
        end
        S_DONE: begin
          if (digest_ready) begin
            r_h     <= word_to_hw(IV_INIT);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state only; rst_n gating keeps msg_ready low while reset is held.
  always_comb begin
    round_state  = S_IDLE;
    round_h_in   = '0;
    round_iv     = '0;
    msg_ready    = 1'b0;
    digest_valid = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        msg_ready = rst_n;
        busy      = 1'b0;
      end
      S_CALC_SA: begin
        round_state = S_CALC_SA;
        round_h_in  = r_w;
        round_iv    = r_h;
      end
      S_CALC_ROUND: begin
        round_state = S_CALC_ROUND;
        round_h_in  = r_h;
        round_iv    = w_iv_round;
      end
      S_DONE: begin
        round_state  = S_DONE;
        digest_valid = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  assign digest = hw_to_word(r_h);

`ifdef HASH_ROUND_CTRL_PERF_CNT_EN
  logic [31:0] r_perf_rounds;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_rounds <= '0;
    end else if ((r_state == S_CALC_SA || r_state == S_CALC_ROUND) &&
                 (r_perf_rounds != 32'hFFFF_FFFF)) begin
      r_perf_rounds <= r_perf_rounds + 32'd1;
    end
  end

  assign perf_rounds = r_perf_rounds;
`endif

endmodule
